// File: rtl/reyad.sv
// reyad: 2-bit phase sequencer built from two PN flip-flops.
// REYAD_BINARY_EN selects the binary up-count instead of the Gray cycle.
module reyad_pnff (
  input  logic Clk,
  input  logic rst,
  input  logic i_p,
  input  logic i_n,
  output logic o_q
);

  logic r_q;
  logic w_d;

  // P sets, N clears, both toggles, neither holds
  assign w_d = (i_p & ~r_q) | (~i_n & r_q);

  always_ff @(posedge Clk or negedge rst) begin
    if (!rst) r_q <= 1'b0;
    else      r_q <= w_d;
  end

  assign o_q = r_q;

endmodule

module reyad (
  output logic FA,
  output logic FB,
  input  logic Clk,
  input  logic rst
);

  logic w_pa;
  logic w_na;
  logic w_pb;
  logic w_nb;

`ifdef REYAD_BINARY_EN
  // B toggles every edge, A toggles when B is high
  assign w_pa = FB;
  assign w_na = FB;
  assign w_pb = 1'b1;
  assign w_nb = 1'b1;
`else
  assign w_pa = FB;
  assign w_na = ~FB;
  assign w_pb = ~FA;
  assign w_nb = FA;
`endif

  reyad_pnff u_ffa (
    .Clk (Clk),
    .rst (rst),
    .i_p (w_pa),
    .i_n (w_na),
    .o_q (FA)
  );

  reyad_pnff u_ffb (
    .Clk (Clk),
    .rst (rst),
    .i_p (w_pb),
    .i_n (w_nb),
    .o_q (FB)
  );

endmodule

// File: tb/tb_reyad.sv
// tb_reyad: self-checking bench for the reyad sequencer.
// Model counts accepted edges and maps the count onto the state cycle.
module tb_reyad;

  logic Clk;
  logic rst;
  logic FA;
  logic FB;
  logic p;
  logic n;
  logic pq;

  int n_chk = 0;
  int n_fail = 0;

  // behavioural model: k = clock edges taken since reset released
  int k = 0;
  bit armed = 0;
  bit have_prev = 0;
  logic [1:0] prev;

`ifdef REYAD_BINARY_EN
  logic [1:0] seq [4] = '{2'd0, 2'd1, 2'd2, 2'd3};
  logic [1:0] lit [8] = '{2'd1, 2'd2, 2'd3, 2'd0,
                          2'd1, 2'd2, 2'd3, 2'd0};
`else
  logic [1:0] seq [4] = '{2'd0, 2'd1, 2'd3, 2'd2};
  logic [1:0] lit [8] = '{2'd1, 2'd3, 2'd2, 2'd0,
                          2'd1, 2'd3, 2'd2, 2'd0};
`endif

  logic       pn_p [5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
  logic       pn_n [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
  logic       pn_q [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};

  reyad dut (
    .FA  (FA),
    .FB  (FB),
    .Clk (Clk),
    .rst (rst)
  );

  reyad_pnff u_pn (
    .Clk (Clk),
    .rst (rst),
    .i_p (p),
    .i_n (n),
    .o_q (pq)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  task automatic chk(input string name, input logic [1:0] act,
                     input logic [1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t",
               name, act, exp, $time);
    end
  endtask

  always @(negedge rst) k = 0;

  always @(posedge Clk) if (armed) k++;

  always @(negedge Clk) begin
    logic [1:0] cur;
    logic [1:0] exp;
    cur = {FA, FB};
    exp = rst ? seq[k % 4] : 2'd0;
    chk("model", cur, exp);
`ifndef REYAD_BINARY_EN
    if (armed && rst && have_prev) begin
      n_chk++;
      if ($countones(cur ^ prev) != 1) begin
        n_fail++;
        $display("FAIL gray_step: got %b after %b", cur, prev);
      end
    end
`endif
    have_prev = armed && rst;
    prev = cur;
    armed = rst;
  end

  initial begin
    int d;
    int h;
    rst = 1'b0;
    p = 1'b0;
    n = 1'b0;
    repeat (3) @(negedge Clk);
    chk("reset_hold", {FA, FB}, 2'd0);

    @(posedge Clk);
    #2 rst = 1'b1;
    @(negedge Clk);
    for (int i = 0; i < 8; i++) begin
      @(negedge Clk);
      chk("lit_seq", {FA, FB}, lit[i]);
    end

    // advance two steps, then assert reset between edges
    @(posedge Clk);
    @(posedge Clk);
    #2 rst = 1'b0;
    #1 chk("async_clr", {FA, FB}, 2'd0);
    repeat (2) @(negedge Clk);
    chk("clr_hold", {FA, FB}, 2'd0);
    @(posedge Clk);
    #2 rst = 1'b1;
    @(negedge Clk);
    @(negedge Clk);
    chk("post_rel", {FA, FB}, 2'd1);

    // release exactly on an edge: that edge must not count
    @(posedge Clk);
    #2 rst = 1'b0;
    @(negedge Clk);
    @(posedge Clk);
    rst <= 1'b1;
    @(negedge Clk);
    chk("coinc_hold", {FA, FB}, 2'd0);
    @(negedge Clk);
    chk("coinc_next", {FA, FB}, 2'd1);

    for (int i = 0; i < 5; i++) begin
      p = pn_p[i];
      n = pn_n[i];
      @(negedge Clk);
      chk("pn_cell", {1'b0, pq}, {1'b0, pn_q[i]});
    end
    p = 1'b0;
    n = 1'b0;

    for (int it = 0; it < 40; it++) begin
      repeat ($urandom_range(1, 9)) @(negedge Clk);
      if ($urandom_range(0, 2) == 0) begin
        @(posedge Clk);
        d = $urandom_range(1, 4);
        #(d) rst = 1'b0;
        #1 chk("rnd_clr", {FA, FB}, 2'd0);
        h = $urandom_range(0, 3);
        repeat (h) @(negedge Clk);
        @(posedge Clk);
        if ($urandom_range(0, 1) == 0) begin
          rst <= 1'b1;
        end else begin
          d = $urandom_range(1, 4);
          #(d) rst = 1'b1;
        end
      end
    end
    repeat (4) @(negedge Clk);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
